// File: rtl/icache_pkg.sv
// Types and defaults shared by the instruction and data caches.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_N_SETS     = 2;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/icache_byte_select.sv
// Big-endian byte/word extraction from a cache line; bytes past the line end read as zero.
module icache_byte_select
  import icache_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int OFF_W      = clog2(LINE_BYTES)
) (
  input  logic [8*LINE_BYTES-1:0] line,
  input  logic [OFF_W-1:0]        off,
  input  logic                    size,
  output logic [31:0]             data
);

  // Line byte 0 sits at the MSB; output byte 0 is data[31:24].
  always_comb begin
    data = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if ((i == 0 || size) && (int'(off) + i < LINE_BYTES)) begin
        data[8*(3-i) +: 8] = line[8*(LINE_BYTES-1-(int'(off)+i)) +: 8];
      end else begin
        data[8*(3-i) +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/icache_assoc2_param.sv
// 2-way set-associative instruction cache with per-set LRU, line refill and
// multi-cycle flush.
module icache_assoc2_param
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int N_SETS     = DEF_N_SETS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    size,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    flush,
  output logic                    hit,
  output logic [31:0]             data,
  output logic                    busy,
  output logic [ADDR_W-1:0]       mem_bus_address,
  output logic                    mem_read_start,
  input  logic [8*LINE_BYTES-1:0] mem_bus_data,
  input  logic                    mem_read_rdy
);

  localparam int OFF_W  = clog2(LINE_BYTES);
  localparam int IDX_W  = clog2(N_SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(N_SETS - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    fcnt_q, fcnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic                mem_read_start_q, mem_read_start_d;
  logic [ADDR_W-1:0]   mem_bus_address_q, mem_bus_address_d;
  logic                valid_q [2][N_SETS];
  logic                valid_d [2][N_SETS];
  logic                lru_q [N_SETS];
  logic                lru_d [N_SETS];
  logic [TAG_W-1:0]    tag_q [2][N_SETS];
  logic [TAG_W-1:0]    tag_d [2][N_SETS];
  logic [LINE_W-1:0]   line_q [2][N_SETS];
  logic [LINE_W-1:0]   line_d [2][N_SETS];

  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [OFF_W-1:0]    req_off;
  logic [1:0]          way_hit;
  logic                hit_way, fill_way;
  logic [LINE_W-1:0]   hit_line;

  assign req_tag  = address[ADDR_W-1 -: TAG_W];
  assign req_idx  = address[OFF_W +: IDX_W];
  assign req_off  = address[OFF_W-1:0];
  assign fill_tag = mem_bus_address_q[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_bus_address_q[OFF_W +: IDX_W];

  // Lookup and victim selection; lru holds the most recently used way.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
    end
    hit      = (state_q != FLUSH) && (|way_hit);
    hit_way  = ~way_hit[0];
    hit_line = hit_way ? line_q[1][req_idx] : line_q[0][req_idx];
    if (!valid_q[0][fill_idx]) begin
      fill_way = 1'b0;
    end else if (!valid_q[1][fill_idx]) begin
      fill_way = 1'b1;
    end else begin
      fill_way = ~lru_q[fill_idx];
    end
  end

  icache_byte_select #(
    .LINE_BYTES (LINE_BYTES),
    .OFF_W      (OFF_W)
  ) u_byte_select (
    .line (hit_line),
    .off  (req_off),
    .size (size),
    .data (data)
  );

  // Next-state logic for the controller and the cache arrays.
  always_comb begin
    state_d           = state_q;
    fcnt_d            = fcnt_q;
    flush_pend_d      = flush_pend_q;
    mem_read_start_d  = mem_read_start_q;
    mem_bus_address_d = mem_bus_address_q;
    valid_d           = valid_q;
    lru_d             = lru_q;
    tag_d             = tag_q;
    line_d            = line_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          fcnt_d  = {IDX_W{1'b0}};
        end else if (cs && !hit) begin
          state_d           = REQ;
          mem_bus_address_d = {req_tag, req_idx, {OFF_W{1'b0}}};
          mem_read_start_d  = 1'b1;
        end else if (cs) begin
          lru_d[req_idx] = hit_way;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (mem_read_rdy) begin
          tag_d[fill_way][fill_idx]   = fill_tag;
          line_d[fill_way][fill_idx]  = mem_bus_data;
          valid_d[fill_way][fill_idx] = 1'b1;
          lru_d[fill_idx]             = fill_way;
          mem_read_start_d            = 1'b0;
          // A flush that arrived during the refill runs right after the line lands.
          if (flush_pend_q || flush) begin
            state_d      = FLUSH;
            fcnt_d       = {IDX_W{1'b0}};
            flush_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REQ;
        end
      end
      FLUSH: begin
        valid_d[0][fcnt_q] = 1'b0;
        valid_d[1][fcnt_q] = 1'b0;
        if (fcnt_q == LAST_SET) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and valid/LRU bits, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      fcnt_q            <= {IDX_W{1'b0}};
      flush_pend_q      <= 1'b0;
      mem_read_start_q  <= 1'b0;
      mem_bus_address_q <= {ADDR_W{1'b0}};
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
        lru_q[s]      <= 1'b0;
      end
    end else begin
      state_q           <= state_d;
      fcnt_q            <= fcnt_d;
      flush_pend_q      <= flush_pend_d;
      mem_read_start_q  <= mem_read_start_d;
      mem_bus_address_q <= mem_bus_address_d;
      valid_q           <= valid_d;
      lru_q             <= lru_d;
    end
  end

  // Tag and line storage are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign mem_bus_address = mem_bus_address_q;
  assign mem_read_start  = mem_read_start_q;
  assign busy            = (state_q != IDLE) | flush_pend_q;

endmodule

// File: tb/tb_icache_assoc2_param.sv
// Self-checking bench for icache_assoc2_param: directed scenarios plus a randomized
// run against a recency-ordered per-set reference model.
module tb_icache_assoc2_param;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int N_SETS     = 2;

  logic         clk = 1'b0;
  logic         reset, cs, size, flush, mem_read_rdy;
  logic [31:0]  address;
  logic [127:0] mem_bus_data;
  logic         hit, busy, mem_read_start;
  logic [31:0]  data, mem_bus_address;

  int checks = 0;
  int failures = 0;

  // Reference model: per set, up to two resident lines, index 0 most recent.
  int           m_cnt [2];
  logic [26:0]  m_tag [2][2];
  logic [127:0] m_line [2][2];

  always #5 clk = ~clk;

  icache_assoc2_param #(
    .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .N_SETS(N_SETS)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .size(size), .address(address),
    .flush(flush), .hit(hit), .data(data), .busy(busy),
    .mem_bus_address(mem_bus_address), .mem_read_start(mem_read_start),
    .mem_bus_data(mem_bus_data), .mem_read_rdy(mem_read_rdy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_data(logic [127:0] line, int off, logic sz);
    logic [31:0] r;
    logic [7:0]  v;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      int b;
      b = off + k;
      v = 8'h00;
      if (b < 16 && (k == 0 || sz)) v = 8'(line >> (8 * (15 - b)));
      r = (r << 8) | 32'(v);
    end
    return r;
  endfunction

  function automatic int model_pos(logic [31:0] a);
    int s;
    s = int'(a[4]);
    for (int p = 0; p < m_cnt[s]; p++) if (m_tag[s][p] == a[31:5]) return p;
    return -1;
  endfunction

  task automatic model_clear();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic model_touch(logic [31:0] a);
    int s, p;
    logic [26:0]  t;
    logic [127:0] l;
    s = int'(a[4]);
    p = model_pos(a);
    if (p == 1) begin
      t = m_tag[s][0]; l = m_line[s][0];
      m_tag[s][0] = m_tag[s][1]; m_line[s][0] = m_line[s][1];
      m_tag[s][1] = t; m_line[s][1] = l;
    end
  endtask

  task automatic model_fill(logic [31:0] a, logic [127:0] line);
    int s;
    s = int'(a[4]);
    m_tag[s][1] = m_tag[s][0]; m_line[s][1] = m_line[s][0];
    m_tag[s][0] = a[31:5];     m_line[s][0] = line;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset = 1'b1; cs = 1'b0; size = 1'b0; flush = 1'b0;
    address = 32'h0; mem_bus_data = 128'h0; mem_read_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Stimulus only: refill a line known to miss.
  task automatic fill_line(logic [31:0] a, logic [127:0] line);
    cs = 1'b1; size = 1'b1; address = a;
    tick();
    cs = 1'b0; mem_bus_data = line; mem_read_rdy = 1'b1;
    tick();
    mem_read_rdy = 1'b0;
    model_fill(a, line);
  endtask

  task automatic test_reset();
    do_reset();
    address = 32'h100;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (mem_read_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b want=0", mem_read_start); end
    checks++; if (mem_bus_address !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", mem_bus_address); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b want=0", hit); end
  endtask

  task automatic test_basic();
    logic [127:0] l;
    l = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    cs = 1'b1; size = 1'b1; address = 32'h100;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL basic_miss got=%b want=0", hit); end
    tick();
    checks++; if (mem_read_start !== 1'b1) begin failures++; $display("FAIL basic_start got=%b want=1", mem_read_start); end
    checks++; if (mem_bus_address !== 32'h100) begin failures++; $display("FAIL basic_maddr got=%h want=100", mem_bus_address); end
    mem_bus_data = l; mem_read_rdy = 1'b1;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL basic_early_hit got=%b want=0", hit); end
    tick();
    mem_read_rdy = 1'b0;
    model_fill(32'h100, l);
    #1;
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL basic_hit got=%b want=1", hit); end
    checks++; if (data !== 32'h00112233) begin failures++; $display("FAIL basic_word got=%h want=00112233", data); end
    checks++; if (mem_read_start !== 1'b0) begin failures++; $display("FAIL basic_start_clr got=%b want=0", mem_read_start); end
    cs = 1'b0; address = 32'h10D; size = 1'b1;
    #1;
    checks++; if (data !== 32'hDDEEFF00) begin failures++; $display("FAIL edge_word got=%h want=DDEEFF00", data); end
    address = 32'h105; size = 1'b0;
    #1;
    checks++; if (data !== 32'h55000000) begin failures++; $display("FAIL byte_read got=%h want=55000000", data); end
    tick();
  endtask

  task automatic test_lru();
    logic [127:0] la, lb, lc, ls;
    do_reset();
    la = rand_line(); lb = rand_line(); lc = rand_line(); ls = rand_line();
    fill_line(32'h010, ls);
    fill_line(32'h000, la);
    fill_line(32'h020, lb);
    cs = 1'b1; size = 1'b1; address = 32'h000;
    #1;
    checks++; if (hit !== 1'b1 || data !== exp_data(la, 0, 1'b1)) begin failures++; $display("FAIL lru_hit0 hit=%b data=%h want hit=1 data=%h", hit, data, exp_data(la, 0, 1'b1)); end
    tick();
    model_touch(32'h000);
    address = 32'h040;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL lru_miss40 got=%b want=0", hit); end
    fill_line(32'h040, lc);
    address = 32'h020;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL lru_evicted20 got=%b want=0", hit); end
    address = 32'h000;
    #1;
    checks++; if (hit !== 1'b1 || data !== exp_data(la, 0, 1'b1)) begin failures++; $display("FAIL lru_kept0 hit=%b data=%h", hit, data); end
    address = 32'h046;
    #1;
    checks++; if (hit !== 1'b1 || data !== exp_data(lc, 6, 1'b1)) begin failures++; $display("FAIL lru_new40 hit=%b data=%h want %h", hit, data, exp_data(lc, 6, 1'b1)); end
    address = 32'h01E;
    #1;
    checks++; if (hit !== 1'b1 || data !== exp_data(ls, 14, 1'b1)) begin failures++; $display("FAIL lru_set1 hit=%b data=%h want %h", hit, data, exp_data(ls, 14, 1'b1)); end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] addrs [4];
    addrs = '{32'h000, 32'h020, 32'h010, 32'h030};
    do_reset();
    for (int i = 0; i < 4; i++) fill_line(addrs[i], rand_line());
    for (int i = 0; i < 4; i++) begin
      address = addrs[i];
      #1;
      checks++; if (hit !== 1'b1) begin failures++; $display("FAIL flush_pre_hit a=%h got=%b want=1", addrs[i], hit); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < N_SETS; i++) begin
      address = addrs[3 - i];
      #1;
      checks++; if (busy !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL flush_busy cyc=%0d busy=%b hit=%b want busy=1 hit=0", i, busy, hit); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_done busy=%b want=0", busy); end
    model_clear();
    for (int i = 0; i < 4; i++) begin
      address = addrs[i];
      #1;
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL flush_post_miss a=%h got=%b want=0", addrs[i], hit); end
    end
  endtask

  task automatic test_req_flush();
    do_reset();
    cs = 1'b1; size = 1'b1; address = 32'h200;
    tick();
    address = 32'h300; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (mem_bus_address !== 32'h200 || mem_read_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL reqf_hold addr=%h start=%b busy=%b want 200/1/1", mem_bus_address, mem_read_start, busy); end
    tick();
    checks++; if (mem_bus_address !== 32'h200) begin failures++; $display("FAIL reqf_hold2 addr=%h want=200", mem_bus_address); end
    mem_bus_data = rand_line(); mem_read_rdy = 1'b1;
    tick();
    mem_read_rdy = 1'b0; cs = 1'b0; address = 32'h200;
    for (int i = 0; i < N_SETS; i++) begin
      #1;
      checks++; if (busy !== 1'b1 || hit !== 1'b0 || mem_read_start !== 1'b0) begin failures++; $display("FAIL reqf_flush cyc=%0d busy=%b hit=%b start=%b", i, busy, hit, mem_read_start); end
      tick();
    end
    checks++; if (busy !== 1'b0 || hit !== 1'b0) begin failures++; $display("FAIL reqf_after busy=%b hit=%b want 0/0", busy, hit); end
    address = 32'h300;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reqf_300 got=%b want=0", hit); end
    model_clear();
  endtask

  task automatic test_reset_in_req();
    cs = 1'b1; size = 1'b1; address = 32'h400;
    tick();
    cs = 1'b0;
    checks++; if (mem_read_start !== 1'b1) begin failures++; $display("FAIL rreq_start got=%b want=1", mem_read_start); end
    reset = 1'b1;
    #1;
    checks++; if (mem_read_start !== 1'b0 || busy !== 1'b0 || mem_bus_address !== 32'h0) begin failures++; $display("FAIL rreq_async start=%b busy=%b addr=%h", mem_read_start, busy, mem_bus_address); end
    #2 reset = 1'b0;
    model_clear();
    mem_bus_data = rand_line(); mem_read_rdy = 1'b1;
    tick();
    mem_read_rdy = 1'b0;
    #1;
    checks++; if (hit !== 1'b0 || busy !== 1'b0 || mem_read_start !== 1'b0) begin failures++; $display("FAIL rreq_ignored hit=%b busy=%b start=%b", hit, busy, mem_read_start); end
  endtask

  task automatic test_random();
    logic [31:0]  a;
    logic [127:0] l;
    int p;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 1) << 4) | $urandom_range(0, 15);
      mem_read_rdy = 1'($urandom_range(0, 1));
      mem_bus_data = rand_line();
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1; cs = 1'($urandom_range(0, 1)); address = a;
        tick();
        flush = 1'b0; cs = 1'b0; mem_read_rdy = 1'b0;
        for (int i = 0; i < N_SETS; i++) begin
          #1;
          checks++; if (busy !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL rnd_flush it=%0d busy=%b hit=%b", it, busy, hit); end
          tick();
        end
        model_clear();
        continue;
      end
      cs = ($urandom_range(0, 3) != 0); size = 1'($urandom_range(0, 1)); address = a;
      #1;
      p = model_pos(a);
      checks++; if (hit !== (p >= 0)) begin failures++; $display("FAIL rnd_hit it=%0d a=%h got=%b want=%b", it, a, hit, p >= 0); end
      if (p >= 0) begin
        checks++; if (data !== exp_data(m_line[a[4]][p], int'(a[3:0]), size)) begin failures++; $display("FAIL rnd_data it=%0d a=%h got=%h want=%h", it, a, data, exp_data(m_line[a[4]][p], int'(a[3:0]), size)); end
      end
      tick();
      mem_read_rdy = 1'b0;
      if (cs && p >= 0) model_touch(a);
      if (cs && p < 0) begin
        checks++; if (mem_read_start !== 1'b1 || mem_bus_address !== {a[31:4], 4'h0}) begin failures++; $display("FAIL rnd_req it=%0d start=%b addr=%h want %h", it, mem_read_start, mem_bus_address, {a[31:4], 4'h0}); end
        repeat ($urandom_range(0, 3)) begin
          address = $urandom_range(0, 255);
          tick();
          checks++; if (mem_bus_address !== {a[31:4], 4'h0} || busy !== 1'b1) begin failures++; $display("FAIL rnd_wait it=%0d addr=%h busy=%b", it, mem_bus_address, busy); end
        end
        l = rand_line();
        mem_bus_data = l; mem_read_rdy = 1'b1;
        tick();
        mem_read_rdy = 1'b0; cs = 1'b0; address = a;
        model_fill(a, l);
        #1;
        checks++; if (hit !== 1'b1 || data !== exp_data(l, int'(a[3:0]), size)) begin failures++; $display("FAIL rnd_fill it=%0d hit=%b data=%h want %h", it, hit, data, exp_data(l, int'(a[3:0]), size)); end
        tick();
      end
    end
    cs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lru();
    test_flush();
    test_req_flush();
    test_reset_in_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
